seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default `WORD (64), operand width in bits.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 start  in  1  request; sampled on rising clk only while busy=0.
REQ-005 signed_op  in  1  1 = two's-complement operands (SMULH-style), 0 = unsigned (UMULH-style); captured with start.
REQ-006 multiplicand  in  WIDTH  operand A; captured with start.
REQ-007 multiplier  in  WIDTH  operand B; captured with start.
REQ-008 busy  out  1  high while an operation is in progress.
REQ-009 done  out  1  single-cycle pulse marking valid results.
REQ-010 product_lo  out  WIDTH  bits [WIDTH-1:0] of the 2*WIDTH-bit product (MUL result).
REQ-011 product_hi  out  WIDTH  bits [2*WIDTH-1:WIDTH] of the product (UMULH/SMULH result).

Function
REQ-012 FSM states: IDLE, CALC, FIX, DONE; no other reachable state.
REQ-013 IDLE/DONE with start=1 at edge E: capture operands and signed_op, go to CALC, load bit counter = WIDTH.
REQ-014 Capture: signed_op=1 stores |A|, |B| and result sign = A[WIDTH-1] XOR B[WIDTH-1]; signed_op=0 stores A, B unchanged and sign = 0.
REQ-015 CALC: one radix-2 shift-add step per cycle (if multiplier LSB = 1 add multiplicand to upper accumulator half, then shift accumulator right 1 with carry-in); counter decrements each cycle.
REQ-016 Accumulator is 2*WIDTH+1 bits so the add carry is never lost.
REQ-017 CALC -> FIX after exactly WIDTH steps (edges E+1 .. E+WIDTH).
REQ-018 FIX (edge E+WIDTH+1): if sign = 1, 2*WIDTH-bit two's-complement negate of accumulator; else unchanged; go to DONE.
REQ-019 DONE lasts one cycle: done=1, busy=0; next edge goes to IDLE unless start=1 (REQ-013 then applies, back-to-back).
REQ-020 Latency: start sampled at edge E -> done high for the cycle after edge E+WIDTH+1 (WIDTH+2 edges).
REQ-021 busy=1 in CALC and FIX only; start while busy=1 is ignored, operands not re-captured, operation unaffected.
REQ-022 product_lo/product_hi update only at the FIX edge; held stable through DONE and IDLE until the next FIX edge.
REQ-023 Input changes on multiplicand/multiplier/signed_op outside the capture edge do not affect the result.
REQ-024 Signed -2^(WIDTH-1) operands: magnitude 2^(WIDTH-1) is represented unsigned in WIDTH bits, result exact (no overflow, no saturation).
REQ-025 Zero operand: full WIDTH steps still taken, result 0, sign fix yields 0 (no negative zero issue).

Reset
REQ-026 reset low: state = IDLE, busy=0, done=0, product_lo=0, product_hi=0, accumulator and counter cleared.
REQ-027 reset low mid-operation (CALC or FIX): operation aborted, outputs per REQ-026, no done pulse produced.
REQ-028 After reset release, first rising edge with start=1 begins a new operation per REQ-013.

Verification
REQ-029 Unsigned 57 x 8, start at edge E -> done in cycle after E+65; product_lo=456, product_hi=0; busy high exactly 65 cycles.
REQ-030 Signed -7 x 3 -> product_lo=0xFFFF_FFFF_FFFF_FFEB, product_hi=0xFFFF_FFFF_FFFF_FFFF.
REQ-031 Unsigned 0xFFFF_FFFF_FFFF_FFFF squared -> product_lo=0x1, product_hi=0xFFFF_FFFF_FFFF_FFFE; signed -2^63 x -1 -> product_lo=0x8000_0000_0000_0000, product_hi=0.
REQ-032 Start 5 x 6, pulse start with 9 x 9 at cycle 10 of CALC -> done once, result 30, no second operation.
REQ-033 Reset low at cycle 20 of CALC -> busy=0, done=0, products=0 immediately (async); no done pulse afterwards; next 3 x 4 -> 12.
REQ-034 Back-to-back: start held high in DONE cycle with 2 x 2 -> second done exactly WIDTH+2 edges later, result 4; first result visible until second FIX edge.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, WIDTH+2 cycles per operation,
// signed (sign-magnitude with final negate) or unsigned operands.
`default_nettype none

`ifndef WORD
`define WORD 64
`endif

module seq_multiplier #(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH:0]     acc;
  logic [CW-1:0]        count;
  logic                 sign;

  logic                 load;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   fixed;

  assign load  = start && (state == IDLE || state == DONE);
  // The most negative value maps to 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  assign abs_a = (signed_op && multiplicand[WIDTH-1]) ? (~multiplicand + ONE_W) : multiplicand;
  assign abs_b = (signed_op && multiplier[WIDTH-1])   ? (~multiplier + ONE_W)   : multiplier;
  assign sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign fixed = sign ? (~acc[2*WIDTH-1:0] + ONE_2W) : acc[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mcand      <= '0;
      acc        <= '0;
      count      <= '0;
      sign       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_lo <= '0;
      product_hi <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        mcand <= abs_a;
        acc   <= {{(WIDTH+1){1'b0}}, abs_b};
        sign  <= signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        count <= CW'(WIDTH);
        busy  <= 1'b1;
        state <= CALC;
      end else begin
        case (state)
          CALC: begin
            // Shift the carry-extended sum right together with the remaining multiplier bits.
            acc   <= {1'b0, sum, acc[WIDTH-1:1]};
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FIX;
          end
          FIX: begin
            acc        <= {1'b0, fixed};
            product_lo <= fixed[WIDTH-1:0];
            product_hi <= fixed[2*WIDTH-1:WIDTH];
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier with hand-computed products.
`default_nettype none

module tb_seq_multiplier;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product_lo;
  logic [W-1:0] product_hi;

  int n_chk = 0;
  int n_fail = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .signed_op    (signed_op),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_lo   (product_lo),
    .product_hi   (product_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start at edge E, scramble inputs afterwards, optionally pulse start while busy.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                        input int intrude);
    int n;
    int busy_cnt;
    int bad_idle;
    bit seen;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    signed_op    = s;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = 64'hDEAD_BEEF_0BAD_F00D;
    multiplier   = 64'h1234_5678_9ABC_DEF0;
    signed_op    = ~s;
    n = 0;
    busy_cnt = busy ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < W + 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (n == intrude) begin
          start = 1'b1;
          multiplicand = 64'd9;
          multiplier   = 64'd9;
        end else if (n == intrude + 1) begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(W + 1));
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " lo"}, product_lo, exp_lo);
    chk({tag, " hi"}, product_hi, exp_hi);
    bad_idle = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done || busy || product_lo !== exp_lo || product_hi !== exp_hi) bad_idle++;
    end
    chk({tag, " idle_hold"}, 64'(bad_idle), 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int held_bad;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset lo", product_lo, 64'd0);
    chk("reset hi", product_hi, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("u57x8", 64'd57, 64'd8, 1'b0, 64'd456, 64'd0, -10);
    run_op("s-7x3", -64'sd7, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFF, -10);
    run_op("umax_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'h1, 64'hFFFF_FFFF_FFFF_FFFE, -10);
    run_op("smin_x_m1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
           64'h8000_0000_0000_0000, 64'd0, -10);
    run_op("smin_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
           64'd0, 64'h4000_0000_0000_0000, -10);
    run_op("s0x-5", 64'd0, -64'sd5, 1'b1, 64'd0, 64'd0, -10);
    run_op("u5x6_intrude", 64'd5, 64'd6, 1'b0, 64'd30, 64'd0, 10);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    multiplicand = 64'd5;
    multiplier   = 64'd7;
    signed_op    = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async busy", 64'(busy), 64'd0);
    chk("async done", 64'(done), 64'd0);
    chk("async lo", product_lo, 64'd0);
    chk("async hi", product_hi, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("no_done_after_reset", 64'(pulses), 64'd0);
    run_op("u3x4", 64'd3, 64'd4, 1'b0, 64'd12, 64'd0, -10);

    // Back-to-back: start held during the DONE cycle.
    @(negedge clk);
    multiplicand = 64'd7;
    multiplier   = 64'd9;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("b2b first_done", 64'(seen), 64'd1);
    chk("b2b first_lo", product_lo, 64'd63);
    start        = 1'b1;
    multiplicand = 64'd2;
    multiplier   = 64'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b busy_restart", 64'(busy), 64'd1);
    n = 0;
    held_bad = 0;
    seen = 1'b0;
    for (int i = 0; i < W + 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
      else if (product_lo !== 64'd63) held_bad++;
    end
    chk("b2b latency", 64'(n), 64'(W + 1));
    chk("b2b first_held", 64'(held_bad), 64'd0);
    chk("b2b second_lo", product_lo, 64'd4);
    chk("b2b second_hi", product_hi, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
